// File: rtl/beam_trig_pkg.sv
// Shared types and defaults for the beamform_trigger threshold load path.
package beam_trig_pkg;
    localparam int              THRESH_BITS    = 18;
    localparam logic [17:0]     THRESH_DEFAULT = 18'h3FFFF;

    typedef enum logic [1:0] {IDLE, LOAD, UPDATE, HOLD} thr_state_t;
endpackage

// File: rtl/beam_threshold_sequencer.sv
// Stages per-beam thresholds and, on commit, streams dirty beams to the trigger,
// then issues one update pulse and a settle holdoff.
module beam_threshold_sequencer #(
    parameter int                          NBEAMS         = 2,
    parameter int                          THRESH_BITS    = beam_trig_pkg::THRESH_BITS,
    parameter logic [THRESH_BITS-1:0]      THRESH_DEFAULT = beam_trig_pkg::THRESH_DEFAULT,
    parameter int                          HOLDOFF        = 4,
    localparam int                         ADDR_BITS      = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   wr_en_i,
    input  logic [ADDR_BITS-1:0]   wr_addr_i,
    input  logic [THRESH_BITS-1:0] wr_data_i,
    input  logic                   commit_i,
    output logic [THRESH_BITS-1:0] thresh_o,
    output logic [NBEAMS-1:0]      thresh_ce_o,
    output logic                   update_o,
    output logic                   busy_o,
    output logic                   done_o
);
    import beam_trig_pkg::*;

    localparam int                   HCNT_BITS = $clog2(HOLDOFF + 1);
    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(NBEAMS - 1);
    localparam logic [HCNT_BITS-1:0] LAST_HOLD = HCNT_BITS'(HOLDOFF - 1);

    thr_state_t             state, state_n;
    logic [THRESH_BITS-1:0] staging [NBEAMS];
    logic [NBEAMS-1:0]      dirty;
    logic                   pending;
    logic [ADDR_BITS-1:0]   idx;
    logic [HCNT_BITS-1:0]   hcnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pending || commit_i) state_n = LOAD;
            LOAD:    if (idx == LAST_IDX)     state_n = UPDATE;
            UPDATE:                           state_n = HOLD;
            HOLD:    if (hcnt == LAST_HOLD)   state_n = IDLE;
            default:                          state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int b = 0; b < NBEAMS; b++) staging[b] <= THRESH_DEFAULT;
            dirty       <= '1;
            pending     <= 1'b1;
            idx         <= '0;
            hcnt        <= '0;
            thresh_o    <= '0;
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= (state != IDLE);
            pending     <= pending | commit_i;
            case (state)
                IDLE: begin
                    if (pending || commit_i) begin
                        pending <= 1'b0;
                        idx     <= '0;
                    end
                end
                LOAD: begin
                    for (int b = 0; b < NBEAMS; b++) begin
                        if (int'(idx) == b && dirty[b]) begin
                            thresh_o       <= staging[b];
                            thresh_ce_o[b] <= 1'b1;
                            dirty[b]       <= 1'b0;
                        end
                    end
                    idx <= idx + ADDR_BITS'(1);
                end
                UPDATE: begin
                    update_o <= 1'b1;
                    hcnt     <= '0;
                end
                HOLD: begin
                    if (hcnt == LAST_HOLD) done_o <= 1'b1;
                    else                   hcnt   <= hcnt + HCNT_BITS'(1);
                end
                default: ;
            endcase
            // Placed after the scan so a same-cycle write keeps the beam dirty.
            for (int b = 0; b < NBEAMS; b++) begin
                if (wr_en_i && int'(wr_addr_i) == b) begin
                    staging[b] <= wr_data_i;
                    dirty[b]   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_beam_threshold_sequencer.sv
// Scoreboard bench: two instances (NBEAMS=2 and NBEAMS=1) share one stimulus stream
// and are checked against a timeline reference model.
module tb_beam_threshold_sequencer;
    localparam int          HOLDOFF = 4;
    localparam logic [17:0] DEF     = 18'h3FFFF;

    typedef struct packed {
        int          tag;
        logic [1:0]  ce;
        logic [17:0] thr;
        logic        upd;
        logic        dn;
    } ev_t;

    typedef struct packed {
        int   tag;
        logic bz;
        logic rst;
    } pe_t;

    typedef struct packed {
        logic [1:0][17:0] stage;
        logic [1:0]       dirty;
        logic             pending;
        logic             active;
        int               k;
    } model_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [0:0]  wr_addr = '0;
    logic [17:0] wr_data = '0;
    logic        commit = 1'b0;

    logic [17:0] th0, th1;
    logic [1:0]  ce0;
    logic [0:0]  ce1;
    logic        up0, up1, bz0, bz1, dn0, dn1;

    int  edge_no = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  started = 0;

    ev_t evq0[$], evq1[$];
    pe_t peq0[$], peq1[$];
    model_t m0, m1;

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    beam_threshold_sequencer #(.NBEAMS(2), .HOLDOFF(HOLDOFF)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .commit_i(commit), .thresh_o(th0), .thresh_ce_o(ce0),
        .update_o(up0), .busy_o(bz0), .done_o(dn0));

    beam_threshold_sequencer #(.NBEAMS(1), .HOLDOFF(HOLDOFF)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .commit_i(commit), .thresh_o(th1), .thresh_ce_o(ce1),
        .update_o(up1), .busy_o(bz1), .done_o(dn1));

    // A pass started at edge k scans beam j at edge k+1+j, pulses update at k+1+n,
    // done at k+1+n+HOLDOFF; the next pass can start no earlier than the edge after.
    task automatic model_edge(input int n, input int e, inout model_t m,
                              output bit has_ev, output ev_t ev, output bit bz);
        int j;
        has_ev = 0;
        ev     = '0;
        ev.tag = e;
        bz     = 0;
        if (!rst_n) begin
            m.stage   = {DEF, DEF};
            m.dirty   = 2'b11;
            m.pending = 1'b1;
            m.active  = 1'b0;
            return;
        end
        if (m.active) begin
            bz = 1;
            j  = e - m.k - 1;
            if (j < n) begin
                if (m.dirty[j]) begin
                    has_ev     = 1;
                    ev.ce      = 2'(1 << j);
                    ev.thr     = m.stage[j];
                    m.dirty[j] = 1'b0;
                end
            end else if (j == n) begin
                has_ev = 1;
                ev.upd = 1'b1;
            end else if (j == n + HOLDOFF) begin
                has_ev   = 1;
                ev.dn    = 1'b1;
                m.active = 1'b0;
            end
            if (commit) m.pending = 1'b1;
        end else if (m.pending || commit) begin
            m.active  = 1'b1;
            m.k       = e;
            m.pending = 1'b0;
        end
        if (wr_en && int'(wr_addr) < n) begin
            m.stage[wr_addr] = wr_data;
            m.dirty[wr_addr] = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit we, input bit a, input logic [17:0] d, input bit c);
        bit  h;
        bit  b;
        ev_t ev;
        int  e;
        @(negedge clk);
        rst_n = r; wr_en = we; wr_addr = a; wr_data = d; commit = c;
        e = edge_no + 1;
        started = 1;
        model_edge(2, e, m0, h, ev, b);
        if (h) evq0.push_back(ev);
        peq0.push_back('{tag: e, bz: b, rst: !r});
        model_edge(1, e, m1, h, ev, b);
        if (h) evq1.push_back(ev);
        peq1.push_back('{tag: e, bz: b, rst: !r});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 18'h0, 0);
    endtask

    task automatic check(input int id, input logic [1:0] ce, input logic [17:0] th,
                         input logic up, input logic dn, input logic bz);
        pe_t pe;
        ev_t ev;
        bit  have_pe, have_ev, shown;
        have_pe = 0;
        have_ev = 0;
        if (id == 0 && peq0.size() > 0 && peq0[0].tag == edge_no) begin pe = peq0.pop_front(); have_pe = 1; end
        if (id == 1 && peq1.size() > 0 && peq1[0].tag == edge_no) begin pe = peq1.pop_front(); have_pe = 1; end
        if (have_pe) begin
            n_checks++;
            if (bz !== pe.bz) begin
                n_fail++;
                $display("FAIL busy dut%0d edge %0d: got %b want %b", id, edge_no, bz, pe.bz);
            end
            if (pe.rst) begin
                n_checks++;
                if (th !== 18'h0 || ce !== 2'b00 || up !== 1'b0 || dn !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_outputs dut%0d edge %0d: got th=%h ce=%b up=%b dn=%b want all 0",
                             id, edge_no, th, ce, up, dn);
                end
            end
        end
        if (id == 0 && evq0.size() > 0 && evq0[0].tag <= edge_no) begin ev = evq0.pop_front(); have_ev = 1; end
        if (id == 1 && evq1.size() > 0 && evq1[0].tag <= edge_no) begin ev = evq1.pop_front(); have_ev = 1; end
        shown = (ce != 2'b00) || up || dn;
        if (shown || have_ev) begin
            n_checks++;
            if (!have_ev) begin
                n_fail++;
                $display("FAIL unexpected_output dut%0d edge %0d: got ce=%b th=%h up=%b dn=%b want none",
                         id, edge_no, ce, th, up, dn);
            end else if (ev.tag != edge_no || ce !== ev.ce || up !== ev.upd || dn !== ev.dn ||
                         (ev.ce != 2'b00 && th !== ev.thr)) begin
                n_fail++;
                $display("FAIL event dut%0d edge %0d: got ce=%b th=%h up=%b dn=%b want edge %0d ce=%b th=%h up=%b dn=%b",
                         id, edge_no, ce, th, up, dn, ev.tag, ev.ce, ev.thr, ev.upd, ev.dn);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                check(0, ce0, th0, up0, dn0, bz0);
                check(1, {1'b0, ce1}, th1, up1, dn1, bz1);
            end
        end
    end

    initial begin
        // reset, then automatic default reload
        repeat (3) step(0, 0, 0, 18'h0, 0);
        idle(12);
        // single dirty beam
        step(1, 1, 1, 18'h01234, 0);
        step(1, 0, 0, 18'h0, 1);
        idle(10);
        // writes during LOAD: beam1 at idx 0 loads now, beam0 at idx 1 waits
        step(1, 1, 1, 18'h0AAAA, 0);
        step(1, 0, 0, 18'h0, 1);
        step(1, 1, 1, 18'h15555, 0);
        step(1, 1, 0, 18'h2BEEF, 0);
        idle(10);
        step(1, 0, 0, 18'h0, 1);
        idle(10);
        // commit with nothing dirty, then three commits during HOLD
        step(1, 0, 0, 18'h0, 1);
        idle(3);
        repeat (3) step(1, 0, 0, 18'h0, 1);
        idle(16);
        // reset mid-LOAD after beam0 is presented
        step(1, 1, 0, 18'h00777, 0);
        step(1, 0, 0, 18'h0, 1);
        step(1, 0, 0, 18'h0, 0);
        step(0, 0, 0, 18'h0, 0);
        idle(14);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(63) != 0), ($urandom_range(2) == 0), 1'($urandom_range(1)),
                 18'($urandom), ($urandom_range(7) == 0));
        idle(20);
        @(posedge clk);
        #2;
        n_checks++;
        if (evq0.size() != 0 || evq1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d events outstanding want 0/0", evq0.size(), evq1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
